// File: rtl/pipe_sequencer_pkg.sv
// Shared CPU definitions for the pipeline sequencer: ALU operation codes,
// major opcodes and the sequencer state encoding.
package pipe_sequencer_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SUB = 3'b010,
        ALU_MUL = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRA = 3'b101,
        ALU_AND = 3'b111
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } seq_state_e;

    // Only these formats carry a real rs2 field; elsewhere [24:20] is immediate.
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pipe_sequencer_if.sv
// Hazard-control bundle between the ID/EX pipeline registers and the sequencer.
interface pipe_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ID_Op_i;
    logic             ID_Eq_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_Rd_i;
    logic [2:0]       EX_ALUOp_i;
    logic             EX_Valid_i;

    logic             PCWrite_o;
    logic             IFID_Write_o;
    logic             IFID_Flush_o;
    logic             IDEX_Bubble_o;
    logic             IDEX_Hold_o;
    logic             EXMEM_Bubble_o;
    logic             BranchTaken_o;
    logic             MUL_Start_o;
    logic [CNT_W-1:0] StallCnt_o;

    modport master (
        output ID_Op_i, ID_Eq_i, EX_MemRead_i, EX_Rd_i, EX_ALUOp_i, EX_Valid_i,
        input  PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, IDEX_Hold_o,
               EXMEM_Bubble_o, BranchTaken_o, MUL_Start_o, StallCnt_o
    );

    modport slave (
        input  ID_Op_i, ID_Eq_i, EX_MemRead_i, EX_Rd_i, EX_ALUOp_i, EX_Valid_i,
        output PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, IDEX_Hold_o,
               EXMEM_Bubble_o, BranchTaken_o, MUL_Start_o, StallCnt_o
    );
endinterface

// File: rtl/pipe_sequencer_mul_timer.sv
// Down-counter tracking the remaining EX cycles of a multi-cycle multiply.
module mul_timer (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [2:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= 3'd0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != 3'd0)) begin
            cnt_reg <= cnt_reg - 3'd1;
        end
    end

    assign zero = (cnt_reg == 3'd0);
endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline hazard sequencer: multi-cycle MUL stall, load-use interlock,
// ID-stage branch resolution and a saturating stall counter.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_sequencer_if.slave  bus
);
    // The first stall cycle is spent in IDLE, so the counter starts two short.
    localparam logic [2:0] MUL_LOAD   = (MUL_LAT > 1) ? 3'(MUL_LAT - 2) : 3'd0;
    localparam logic       MUL_STALLS = (MUL_LAT > 1);

    seq_state_e       state_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic       mul_in_ex;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_zero;
    logic       mul_stall;
    logic       load_use;
    logic       branch_taken;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] opcode;

    assign rs1    = bus.ID_Op_i[19:15];
    assign rs2    = bus.ID_Op_i[24:20];
    assign opcode = bus.ID_Op_i[6:0];

    assign mul_in_ex  = bus.EX_Valid_i && (bus.EX_ALUOp_i == ALU_MUL);
    assign timer_load = (state_reg == ST_IDLE) && mul_in_ex && MUL_STALLS;
    assign timer_dec  = (state_reg == ST_MUL_RUN);
    assign mul_stall  = timer_load || ((state_reg == ST_MUL_RUN) && !timer_zero);

    assign load_use = bus.EX_MemRead_i && (bus.EX_Rd_i != 5'd0) &&
                      ((bus.EX_Rd_i == rs1) || (uses_rs2(opcode) && (bus.EX_Rd_i == rs2)));

    assign branch_taken = (opcode == OPC_BRANCH) && bus.ID_Eq_i && !mul_stall && !load_use;

    mul_timer u_mul_timer (
        .clk      (clk_i),
        .srst     (rst_i),
        .load     (timer_load),
        .load_val (MUL_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    if (timer_load) state_reg <= ST_MUL_RUN;
                ST_MUL_RUN: if (timer_zero) state_reg <= ST_IDLE;
                default:    state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if ((mul_stall || load_use) && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // MUL stall dominates: EX holds the multiply, so ID/EX must hold, not bubble.
    always_comb begin
        bus.PCWrite_o      = 1'b1;
        bus.IFID_Write_o   = 1'b1;
        bus.IFID_Flush_o   = 1'b0;
        bus.IDEX_Bubble_o  = 1'b0;
        bus.IDEX_Hold_o    = 1'b0;
        bus.EXMEM_Bubble_o = 1'b0;
        bus.BranchTaken_o  = 1'b0;
        bus.MUL_Start_o    = 1'b0;
        if (!rst_i) begin
            bus.MUL_Start_o = (state_reg == ST_IDLE) && mul_in_ex;
            if (mul_stall) begin
                bus.PCWrite_o      = 1'b0;
                bus.IFID_Write_o   = 1'b0;
                bus.IDEX_Hold_o    = 1'b1;
                bus.EXMEM_Bubble_o = 1'b1;
            end else if (load_use) begin
                bus.PCWrite_o     = 1'b0;
                bus.IFID_Write_o  = 1'b0;
                bus.IDEX_Bubble_o = 1'b1;
            end else if (branch_taken) begin
                bus.IFID_Flush_o  = 1'b1;
                bus.BranchTaken_o = 1'b1;
            end
        end
    end

    assign bus.StallCnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed scenarios plus a randomized
// run against a cycle-occupancy reference model.
module tb_pipe_sequencer;
    import pipe_sequencer_pkg::*;

    localparam int LAT = 4;
    // Output vector order: PCWrite IFID_Write IFID_Flush IDEX_Bubble IDEX_Hold EXMEM_Bubble BranchTaken MUL_Start
    localparam logic [7:0] V_NORM   = 8'b1100_0000;
    localparam logic [7:0] V_MULST  = 8'b0000_1101;
    localparam logic [7:0] V_MULRUN = 8'b0000_1100;
    localparam logic [7:0] V_LU     = 8'b0001_0000;
    localparam logic [7:0] V_BR     = 8'b1110_0010;
    localparam logic [7:0] V_START1 = 8'b1100_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    pipe_sequencer_if #(.CNT_W(16)) bus ();
    pipe_sequencer_if #(.CNT_W(2))  bus1 ();

    pipe_sequencer #(.MUL_LAT(LAT), .CNT_W(16)) dut  (.clk_i(clk), .rst_i(rst),  .bus(bus));
    pipe_sequencer #(.MUL_LAT(1),   .CNT_W(2))  dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));

    wire [7:0] obs0 = {bus.PCWrite_o, bus.IFID_Write_o, bus.IFID_Flush_o, bus.IDEX_Bubble_o,
                       bus.IDEX_Hold_o, bus.EXMEM_Bubble_o, bus.BranchTaken_o, bus.MUL_Start_o};
    wire [7:0] obs1 = {bus1.PCWrite_o, bus1.IFID_Write_o, bus1.IFID_Flush_o, bus1.IDEX_Bubble_o,
                       bus1.IDEX_Hold_o, bus1.EXMEM_Bubble_o, bus1.BranchTaken_o, bus1.MUL_Start_o};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, opc};
    endfunction

    task automatic drive(input logic [31:0] op, input logic eq, input logic mr,
                         input logic [4:0] rd, input logic [2:0] alu, input logic v);
        bus.ID_Op_i = op; bus.ID_Eq_i = eq; bus.EX_MemRead_i = mr;
        bus.EX_Rd_i = rd; bus.EX_ALUOp_i = alu; bus.EX_Valid_i = v;
    endtask

    task automatic drive1(input logic [31:0] op, input logic mr, input logic [4:0] rd,
                          input logic [2:0] alu, input logic v);
        bus1.ID_Op_i = op; bus1.ID_Eq_i = 1'b0; bus1.EX_MemRead_i = mr;
        bus1.EX_Rd_i = rd; bus1.EX_ALUOp_i = alu; bus1.EX_Valid_i = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        drive(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, ALU_ADD, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; drive_idle(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(mk(OPC_BRANCH, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0, 5'd0, ALU_MUL, 1'b1);
        #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL reset_outputs obs=%b exp=%b", obs0, V_NORM); end
        tick();
        rst = 1'b0; drive_idle(); #2;
        n_checks++;
        if (bus.StallCnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt obs=%0d exp=0", bus.StallCnt_o); end
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL reset_idle obs=%b exp=%b", obs0, V_NORM); end
        tick();
    endtask

    task automatic test_mul();
        logic [7:0] exp_v [4] = '{V_MULST, V_MULRUN, V_MULRUN, V_NORM};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 5'd7, ALU_MUL, 1'b1);
            #2;
            n_checks++;
            if (obs0 !== exp_v[i]) begin n_fail++; $display("FAIL mul_cycle%0d obs=%b exp=%b", i, obs0, exp_v[i]); end
            tick();
        end
        drive_idle(); #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL mul_after obs=%b exp=%b", obs0, V_NORM); end
        n_checks++;
        if (bus.StallCnt_o !== 16'd3) begin n_fail++; $display("FAIL mul_cnt obs=%0d exp=3", bus.StallCnt_o); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(mk(OPC_RTYPE, 5'd5, 5'd1, 5'd6), 1'b0, 1'b1, 5'd5, ALU_ADD, 1'b1); #2;
        n_checks++;
        if (obs0 !== V_LU) begin n_fail++; $display("FAIL lu_rs1 obs=%b exp=%b", obs0, V_LU); end
        tick();
        drive(mk(OPC_RTYPE, 5'd5, 5'd1, 5'd6), 1'b0, 1'b0, 5'd0, ALU_ADD, 1'b0); #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL lu_release obs=%b exp=%b", obs0, V_NORM); end
        tick();
        drive(mk(OPC_RTYPE, 5'd0, 5'd1, 5'd6), 1'b0, 1'b1, 5'd0, ALU_ADD, 1'b1); #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL lu_x0 obs=%b exp=%b", obs0, V_NORM); end
        tick();
        drive(mk(OPC_STORE, 5'd2, 5'd9, 5'd0), 1'b0, 1'b1, 5'd9, ALU_ADD, 1'b1); #2;
        n_checks++;
        if (obs0 !== V_LU) begin n_fail++; $display("FAIL lu_store_rs2 obs=%b exp=%b", obs0, V_LU); end
        tick();
        drive(mk(OPC_OPIMM, 5'd2, 5'd9, 5'd3), 1'b0, 1'b1, 5'd9, ALU_ADD, 1'b1); #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL lu_imm_field obs=%b exp=%b", obs0, V_NORM); end
        tick();
        drive_idle(); #2;
        n_checks++;
        if (bus.StallCnt_o !== 16'd2) begin n_fail++; $display("FAIL lu_cnt obs=%0d exp=2", bus.StallCnt_o); end
        tick();
    endtask

    task automatic test_branch();
        drive(mk(OPC_BRANCH, 5'd3, 5'd4, 5'd0), 1'b1, 1'b0, 5'd0, ALU_ADD, 1'b0); #2;
        n_checks++;
        if (obs0 !== V_BR) begin n_fail++; $display("FAIL br_taken obs=%b exp=%b", obs0, V_BR); end
        tick();
        drive(mk(OPC_BRANCH, 5'd3, 5'd4, 5'd0), 1'b0, 1'b0, 5'd0, ALU_ADD, 1'b0); #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL br_not_taken obs=%b exp=%b", obs0, V_NORM); end
        tick();
    endtask

    task automatic test_load_branch();
        drive(mk(OPC_BRANCH, 5'd5, 5'd2, 5'd0), 1'b1, 1'b1, 5'd5, ALU_ADD, 1'b1); #2;
        n_checks++;
        if (obs0 !== V_LU) begin n_fail++; $display("FAIL ldbr_stall obs=%b exp=%b", obs0, V_LU); end
        tick();
        drive(mk(OPC_BRANCH, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0, 5'd0, ALU_ADD, 1'b0); #2;
        n_checks++;
        if (obs0 !== V_BR) begin n_fail++; $display("FAIL ldbr_resolve obs=%b exp=%b", obs0, V_BR); end
        tick();
    endtask

    task automatic test_mul_reset();
        do_reset();
        drive(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 5'd7, ALU_MUL, 1'b1); #2;
        n_checks++;
        if (obs0 !== V_MULST) begin n_fail++; $display("FAIL mrst_start obs=%b exp=%b", obs0, V_MULST); end
        tick();
        n_checks++;
        if (bus.StallCnt_o !== 16'd1) begin n_fail++; $display("FAIL mrst_cnt1 obs=%0d exp=1", bus.StallCnt_o); end
        rst = 1'b1; #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL mrst_during obs=%b exp=%b", obs0, V_NORM); end
        tick();
        rst = 1'b0; drive_idle(); #2;
        n_checks++;
        if (obs0 !== V_NORM) begin n_fail++; $display("FAIL mrst_after obs=%b exp=%b", obs0, V_NORM); end
        n_checks++;
        if (bus.StallCnt_o !== 16'd0) begin n_fail++; $display("FAIL mrst_cnt0 obs=%0d exp=0", bus.StallCnt_o); end
        tick();
    endtask

    task automatic test_lat1_saturate();
        rst1 = 1'b1; drive1(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, ALU_ADD, 1'b0); tick();
        rst1 = 1'b0;
        drive1(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 5'd7, ALU_MUL, 1'b1); #2;
        n_checks++;
        if (obs1 !== V_START1) begin n_fail++; $display("FAIL lat1_start obs=%b exp=%b", obs1, V_START1); end
        tick();
        drive1(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, ALU_ADD, 1'b0); #2;
        n_checks++;
        if (bus1.StallCnt_o !== 2'd0) begin n_fail++; $display("FAIL lat1_nostall obs=%0d exp=0", bus1.StallCnt_o); end
        for (int k = 1; k <= 5; k++) begin
            drive1(mk(OPC_RTYPE, 5'd4, 5'd1, 5'd2), 1'b1, 5'd4, ALU_ADD, 1'b1); #2;
            n_checks++;
            if (obs1 !== V_LU) begin n_fail++; $display("FAIL sat_stall%0d obs=%b exp=%b", k, obs1, V_LU); end
            tick();
            n_checks++;
            if (int'(bus1.StallCnt_o) !== ((k > 3) ? 3 : k)) begin
                n_fail++; $display("FAIL sat_cnt%0d obs=%0d exp=%0d", k, bus1.StallCnt_o, (k > 3) ? 3 : k);
            end
        end
        drive1(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, ALU_ADD, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] opcs [5] = '{OPC_RTYPE, OPC_STORE, OPC_BRANCH, OPC_LOAD, OPC_OPIMM};
        int occ = 0;
        int exp_cnt = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [6:0] opc; logic [4:0] rs1, rs2, rd; logic [2:0] alu;
            logic mr, v, eq, r_rst, mstall, start, lu, br, rs2_real;
            logic [7:0] exp_v;
            int occ_n;
            opc = opcs[$urandom_range(0, 4)];
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
            mr = 1'($urandom_range(0, 1)); v = ($urandom_range(0, 3) != 0); eq = 1'($urandom_range(0, 1));
            alu = ($urandom_range(0, 5) == 0) ? 3'b011 : 3'b000;
            r_rst = ($urandom_range(0, 49) == 0);
            rst = r_rst;
            drive(mk(opc, rs1, rs2, 5'd1), eq, mr, rd, alu, v);
            occ_n = occ; start = 1'b0; mstall = 1'b0;
            if (occ == 0) begin
                if (v && alu == 3'b011) begin start = 1'b1; mstall = (LAT > 1); occ_n = LAT - 1; end
            end else begin
                mstall = (occ > 1); occ_n = occ - 1;
            end
            rs2_real = (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
            lu = mr && (rd != 0) && ((rd == rs1) || (rs2_real && rd == rs2));
            br = (opc == OPC_BRANCH) && eq && !mstall && !lu;
            exp_v = {!(mstall || lu), !(mstall || lu), br, lu && !mstall, mstall, mstall, br, start};
            if (r_rst) exp_v = V_NORM;
            #2;
            n_checks++;
            if (obs0 !== exp_v) begin n_fail++; $display("FAIL rnd_out%0d obs=%b exp=%b", n, obs0, exp_v); end
            if (r_rst) begin occ = 0; exp_cnt = 0; end
            else begin
                occ = occ_n;
                if ((mstall || lu) && exp_cnt < 65535) exp_cnt++;
            end
            tick();
            n_checks++;
            if (int'(bus.StallCnt_o) !== exp_cnt) begin
                n_fail++; $display("FAIL rnd_cnt%0d obs=%0d exp=%0d", n, bus.StallCnt_o, exp_cnt);
            end
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        drive1(mk(OPC_OPIMM, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, ALU_ADD, 1'b0);
        #1;
        test_reset();
        test_mul();
        test_load_use();
        test_branch();
        test_load_branch();
        test_mul_reset();
        test_lat1_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning the number of cycles a MUL occupies EX (legal range 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ID_Op_i, input, 32, the instruction in ID; rs1=[19:15], rs2=[24:20], opcode=[6:0].
REQ-006 SHALL have port ID_Eq_i, input, 1, meaning the ID-stage register compare is equal (beq taken).
REQ-007 SHALL have ports EX_MemRead_i (input, 1), EX_Rd_i (input, 5), EX_ALUOp_i (input, 3) and EX_Valid_i (input, 1), describing the instruction in EX.
REQ-008 SHALL have ports PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, IDEX_Hold_o, EXMEM_Bubble_o, BranchTaken_o and MUL_Start_o, each output, 1.
REQ-009 SHALL have port StallCnt_o, output, CNT_W, meaning the count of stalled cycles.

Function
REQ-010 SHALL implement FSM states IDLE and MUL_RUN plus a 3-bit down-counter cnt.
REQ-011 SHALL define mul_in_ex as EX_Valid_i and EX_ALUOp_i==3'b011.
REQ-012 When in IDLE with mul_in_ex: SHALL assert MUL_Start_o=1 for that cycle.
REQ-013 When in IDLE with mul_in_ex and MUL_LAT>1: SHALL assert mul_stall, load cnt with MUL_LAT-2 and go to MUL_RUN.
REQ-014 When in MUL_RUN: mul_stall SHALL equal (cnt!=0) and cnt SHALL decrement; when cnt==0 the FSM SHALL return to IDLE, with no stall in that final cycle.
REQ-015 A MUL SHALL occupy EX for exactly MUL_LAT cycles with exactly MUL_LAT-1 stall cycles; MUL_LAT=1 SHALL produce no stall and no state change.
REQ-016 mul_stall SHALL drive PCWrite_o=0, IFID_Write_o=0, IDEX_Hold_o=1 and EXMEM_Bubble_o=1.
REQ-017 SHALL define uses_rs2 as opcode being 0110011, 0100011 or 1100011.
REQ-018 SHALL define load_use as EX_MemRead_i, EX_Rd_i!=0, and (EX_Rd_i==rs1 or (uses_rs2 and EX_Rd_i==rs2)).
REQ-019 load_use without mul_stall SHALL drive PCWrite_o=0, IFID_Write_o=0 and IDEX_Bubble_o=1 for exactly that cycle.
REQ-020 mul_stall SHALL take priority over load_use, forcing IDEX_Bubble_o=0 while IDEX_Hold_o=1.
REQ-021 BranchTaken_o and IFID_Flush_o SHALL be 1 iff opcode==1100011, ID_Eq_i=1, and neither mul_stall nor load_use; a stalled branch SHALL resolve on its unstalled cycle.
REQ-022 With no stall, PCWrite_o and IFID_Write_o SHALL be 1 and all bubble, hold and flush outputs 0.
REQ-023 StallCnt_o SHALL increment by 1 on each cycle with mul_stall or load_use and SHALL saturate at all-ones.
REQ-024 All outputs SHALL be combinational from registered state plus current inputs, with zero-cycle latency.

Reset
REQ-025 While rst_i=1: PCWrite_o=1, IFID_Write_o=1, every other 1-bit output 0, StallCnt_o unaffected until the edge.
REQ-026 At the rst_i edge: state=IDLE, cnt=0, StallCnt_o=0.
REQ-027 Reset during MUL_RUN SHALL abort the MUL sequence, with no stall on the cycle after reset release unless a new mul_in_ex is present.

Structure
REQ-028 ALUOp encodings (ADD 000, SLL 001, SUB 010, MUL 011, XOR 100, SRA 101, AND 111), opcode constants and the state encoding SHALL live in the shared CPU package.
REQ-029 The MUL cycle counter SHALL be a sub-module mul_timer (load, decrement, zero flag); hazard and branch logic SHALL stay in pipe_sequencer.

Verification
REQ-030 MUL_LAT=4, MUL in EX at cycle T -> MUL_Start_o=1 at T; stall outputs high at T, T+1, T+2; normal at T+3; StallCnt_o=3.
REQ-031 lw x5 in EX, add x6,x5,x1 in ID -> one cycle with PCWrite_o=0, IDEX_Bubble_o=1; then normal; lw x0 -> no stall.
REQ-032 beq in ID with ID_Eq_i=1 and no hazard -> BranchTaken_o=IFID_Flush_o=1 for one cycle; ID_Eq_i=0 -> both 0.
REQ-033 lw x5 in EX, beq x5,x2 in ID with ID_Eq_i=1 -> cycle 1: stall, no flush; cycle 2: flush asserted.
REQ-034 rst_i=1 at T+1 of a MUL_LAT=4 MUL -> state IDLE at the following edge, StallCnt_o=0, stall deasserted.
REQ-035 MUL_LAT=1, MUL in EX -> MUL_Start_o=1 and no stall; StallCnt_o forced to near all-ones then 3 stalls -> saturates at all-ones.
